seg7_scan: RTL and testbench
============================

# seg7_scan

Time-multiplexed 4-digit seven-segment driver that sits directly downstream of the traffic-light controller. It consumes the controller's 16-bit packed-BCD countdown word and drives the board's shared digit-select (`sm_wei`) and segment (`sm_duan`) lines. A snapshot of the input is taken once per frame so that a displayed frame never mixes old and new digits. It also provides ghost-suppression blanking between digits, leading-zero blanking and per-digit decimal points.

## Interface
- `SCAN_DIV`, default 50000: cycles per digit slot (1 kHz per digit at 50 MHz); legal range 4..65535.
- `BLANK_CYC`, default 500: cycles at the start of each slot with all digits off; must be < `SCAN_DIV`.
- `clk_50MHz`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `bcd`  in  16  packed BCD; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- `dp_en`  in  4  bit i lights the decimal point of digit i; sampled with `bcd`.
- `lz_blank`  in  1  leading-zero blanking enable; sampled with `bcd`.
- `sm_wei`  out  4  digit select, active-low, one-hot-low; bit i = digit i.
- `sm_duan`  out  8  segments, active-low, order {dp,g,f,e,d,c,b,a}.
- `frame_done`  out  1  one-cycle pulse on the cycle after digit 3's slot ends.

## Operation
- Counters:
  - `div_cnt` runs 0..`SCAN_DIV`-1 and wraps.
  - `dig` runs 0..3 and increments on each `div_cnt` wrap, wrapping 3→0.
- Frame wrap is the edge at which `div_cnt`=`SCAN_DIV`-1 and `dig`=3.
- Shadow registers (`bcd`, `dp_en`, `lz_blank`) load on every edge while `reset`=1 and on every frame-wrap edge. They hold at all other times, so input changes mid-frame are invisible until the next frame.
- Per slot:
  - While `div_cnt` < `BLANK_CYC`: `sm_wei`=4'b1111 and `sm_duan`=8'hFF.
  - Otherwise `sm_wei` = ~(1<<`dig`) and `sm_duan` = decode(shadow digit `dig`), with bit 7 cleared when `dp_en`[`dig`]=1.
- Decode, active-low:
  - Digits 0–9: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90.
  - Nibbles A–F: dash, 8'hBF.
  - Blank: 8'hFF.
- Leading-zero blanking, when shadow `lz_blank`=1:
  - Digit i (i = 3, 2, 1) shows blank segments if it and every higher digit are 0.
  - Digit 0 is never blanked.
  - The decimal point of a blanked digit still obeys `dp_en`.
- The digit select stays active during leading-zero blanking; only the segments go off.
- Reset mid-frame: on the next edge the counters clear to 0 and the outputs return to reset values. Scanning restarts at digit 0 slot start on the first edge with `reset`=0.

## Timing
- Reset values: `sm_wei`=4'b1111, `sm_duan`=8'hFF, `frame_done`=0, `div_cnt`=0, `dig`=0.
- `sm_wei`, `sm_duan` and `frame_done` are registered. Outputs during cycle n reflect the counter state during cycle n-1, a fixed 1-cycle latency.
- First lit output: `sm_wei`=4'b1110 appears `BLANK_CYC`+1 cycles after `reset` deasserts.
- Slot period is exactly `SCAN_DIV` cycles; frame period is exactly 4·`SCAN_DIV` cycles.
- `frame_done` asserts on the cycle the shadow first presents newly loaded data, and lasts 1 cycle.
- Within each slot the lit window is exactly `SCAN_DIV`-`BLANK_CYC` cycles. No two `sm_wei` bits are ever low together.
- Arithmetic:
  - `div_cnt` is 16 bits wide and compares against `SCAN_DIV`-1; no overflow is possible within the legal range.
  - `dig` is 2 bits wide and wraps naturally.

## Structure
- Package `seg7_pkg`:
  - The 8-bit active-low segment constants `SEG_0`..`SEG_9`, `SEG_DASH` and `SEG_BLANK`.
  - The bit index `SEG_DP`=7.
  - The localparam `DIGITS`=4.
- Sub-module `seg7_decode` (purely combinational) maps a 4-bit nibble plus a blank flag to 8-bit segments. `seg7_scan` instantiates it once and muxes the shadow nibble into it by `dig`.
- `seg7_scan` itself holds the counters, the shadow registers, the leading-zero logic and the output registers.

## Test plan
All scenarios use `SCAN_DIV`=8 and `BLANK_CYC`=2.
- Reset release with `bcd`=16'h1234 and `dp_en`=0 → outputs are FF/1111 for 3 cycles, then `sm_wei`=1110 with `sm_duan`=99 for 6 cycles. The frame continues with 1101/B0, 1011/A4 and 0111/F9, each lit window preceded by 2 blank cycles.
- `bcd` changes from 16'h1234 to 16'h5678 during digit 1 of a frame → the rest of that frame still shows 3, 2, 1. `frame_done` pulses once, then the next frame shows 8, 7, 6, 5.
- `lz_blank`=1 with `bcd`=16'h0070 → digits 3 and 2 show FF, digit 1 shows F8 and digit 0 shows C0. With `bcd`=16'h0000 only digit 0 is lit, showing C0.
- `bcd`=16'h9A0F with `dp_en`=4'b0100 → digit 0 shows BF and digit 1 shows C0. Digit 2 shows 3F (dash with dp). Digit 3 shows 90.
- `reset` is pulsed for 1 cycle mid-slot on digit 2 → on the next cycle outputs are FF/1111 and `frame_done`=0. Scanning resumes at digit 0 after `BLANK_CYC`+1 cycles.
- Checker runs continuously across all scenarios → `sm_wei` is never more than one-hot-low. `frame_done` recurs every 32 cycles.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment constants and digit count for the seven-segment scanner
package seg7_pkg;
    localparam int DIGITS = 4;
    localparam int SEG_DP = 7;
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
endpackage

// File: rtl/seg7_scan_if.sv
// seg7_scan_if: countdown word in, multiplexed digit/segment lines out
interface seg7_scan_if;
    import seg7_pkg::*;
    logic [4*DIGITS-1:0] bcd;
    logic [DIGITS-1:0]   dp_en;
    logic                lz_blank;
    logic [DIGITS-1:0]   sm_wei;
    logic [7:0]          sm_duan;
    logic                frame_done;
    modport master (output bcd, dp_en, lz_blank, input sm_wei, sm_duan, frame_done);
    modport slave  (input bcd, dp_en, lz_blank, output sm_wei, sm_duan, frame_done);
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: nibble to active-low segments, dash for A-F, all-off when blanked
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    input  logic       blank_i,
    output logic [7:0] seg_o
);
    // dp bit is always off here; the scanner overlays it
    always_comb begin
        seg_o = SEG_DASH;
        if (blank_i) seg_o = SEG_BLANK;
        else
            case (nib_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_DASH;
            endcase
    end
endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: 4-digit time-multiplexed seven-segment driver with per-frame input snapshot
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic       clk_50MHz,
    input  logic       reset,
    seg7_scan_if.slave bus
);
    localparam logic [15:0] DIV_LAST  = 16'(SCAN_DIV - 1);
    localparam logic [15:0] BLANK_END = 16'(BLANK_CYC);

    logic [15:0]         div_q, div_d;
    logic [1:0]          dig_q, dig_d;
    logic [4*DIGITS-1:0] bcd_q;
    logic [DIGITS-1:0]   dp_q;
    logic                lz_q;
    logic [DIGITS-1:0]   wei_q, wei_d;
    logic [7:0]          duan_q, duan_d;
    logic                fd_q;
    logic                slot_end, wrap, blank, gap;
    logic [DIGITS-1:0]   zero_hi;
    logic [3:0]          nib;
    logic [7:0]          seg;

    seg7_decode u_dec (.nib_i(nib), .blank_i(blank), .seg_o(seg));

    // counter stepping, leading-zero chain and next output values
    always_comb begin
        slot_end   = div_q == DIV_LAST;
        wrap       = slot_end && dig_q == 2'd3;
        div_d      = slot_end ? 16'd0 : div_q + 16'd1;
        dig_d      = dig_q + {1'b0, slot_end};
        nib        = bcd_q[{dig_q, 2'b00} +: 4];
        zero_hi[3] = bcd_q[15:12] == 4'd0;
        zero_hi[2] = zero_hi[3] && bcd_q[11:8] == 4'd0;
        zero_hi[1] = zero_hi[2] && bcd_q[7:4] == 4'd0;
        zero_hi[0] = 1'b0;
        blank      = lz_q && zero_hi[dig_q];
        gap        = div_q < BLANK_END;
        wei_d      = gap ? 4'hF : ~(4'b0001 << dig_q);
        duan_d     = gap ? SEG_BLANK : {seg[SEG_DP] & ~dp_q[dig_q], seg[6:0]};
    end

    // counters, shadow snapshot (during reset and at frame wrap) and output registers
    always_ff @(posedge clk_50MHz) begin
        if (reset || wrap) begin
            bcd_q <= bus.bcd;
            dp_q  <= bus.dp_en;
            lz_q  <= bus.lz_blank;
        end
        if (reset) begin
            div_q  <= 16'd0;
            dig_q  <= 2'd0;
            wei_q  <= 4'hF;
            duan_q <= SEG_BLANK;
            fd_q   <= 1'b0;
        end else begin
            div_q  <= div_d;
            dig_q  <= dig_d;
            wei_q  <= wei_d;
            duan_q <= duan_d;
            fd_q   <= wrap;
        end
    end

    assign bus.sm_wei     = wei_q;
    assign bus.sm_duan    = duan_q;
    assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed and random stimulus against a cycle-count reference model
module tb_seg7_scan;
    localparam int SD = 8;
    localparam int BC = 2;
    localparam logic [7:0] SEG_TAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                             8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectors = 0;
    int errors = 0;
    int p = 0;
    logic [15:0] sh_bcd;
    logic [3:0]  sh_dp;
    logic        sh_lz;

    always #5 clk = ~clk;

    seg7_scan_if bus();

    seg7_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk_50MHz(clk),
        .reset(rst),
        .bus(bus)
    );

    function automatic logic [7:0] exp_duan(int d);
        logic [15:0] hi;
        logic [3:0]  n;
        logic [7:0]  s;
        hi = sh_bcd >> (4 * d);
        n  = hi[3:0];
        if (sh_lz && d > 0 && hi == 16'd0) s = 8'hFF;
        else if (n < 10) s = SEG_TAB[n];
        else s = 8'hBF;
        if (sh_dp[d]) s[7] = 1'b0;
        return s;
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // one clock: predict from inputs present at the edge, then compare after it
    task automatic step();
        logic [3:0]  ew;
        logic [7:0]  ed;
        logic        ef;
        logic [15:0] in_bcd;
        logic [3:0]  in_dp;
        logic        in_lz, in_rst;
        int div, dig;
        in_bcd = bus.bcd;
        in_dp  = bus.dp_en;
        in_lz  = bus.lz_blank;
        in_rst = rst;
        if (in_rst) begin
            ew = 4'hF; ed = 8'hFF; ef = 1'b0;
            sh_bcd = in_bcd; sh_dp = in_dp; sh_lz = in_lz;
            p = 0;
        end else begin
            div = p % SD;
            dig = (p / SD) % 4;
            ew = (div < BC) ? 4'hF : ~(4'b0001 << dig);
            ed = (div < BC) ? 8'hFF : exp_duan(dig);
            ef = (p % (4 * SD)) == (4 * SD - 1);
            if (ef) begin
                sh_bcd = in_bcd; sh_dp = in_dp; sh_lz = in_lz;
            end
            p++;
        end
        @(posedge clk);
        #1;
        chk("sm_wei", {4'h0, bus.sm_wei}, {4'h0, ew});
        chk("sm_duan", bus.sm_duan, ed);
        chk("frame_done", {7'd0, bus.frame_done}, {7'd0, ef});
        chk("wei_onehot", 8'($countones(~bus.sm_wei) <= 1), 8'd1);
    endtask

    initial begin
        logic [15:0] masks [5] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};
        bus.bcd = 16'h1234;
        bus.dp_en = 4'b0000;
        bus.lz_blank = 1'b0;
        repeat (2) step();
        chk("reset_wei", {4'h0, bus.sm_wei}, 8'h0F);
        chk("reset_duan", bus.sm_duan, 8'hFF);
        rst = 1'b0;
        step();
        step();
        chk("pre_lit_wei", {4'h0, bus.sm_wei}, 8'h0F);
        step();
        chk("first_lit_wei", {4'h0, bus.sm_wei}, 8'h0E);
        chk("first_lit_duan", bus.sm_duan, 8'h99);
        while (p != 10) step();
        bus.bcd = 16'h5678;
        repeat (60) step();
        bus.bcd = 16'h0070;
        bus.lz_blank = 1'b1;
        repeat (64) step();
        bus.bcd = 16'h0000;
        repeat (64) step();
        bus.bcd = 16'h9A0F;
        bus.dp_en = 4'b0100;
        bus.lz_blank = 1'b0;
        repeat (64) step();
        while (p % 32 != 20) step();
        rst = 1'b1;
        step();
        chk("midreset_wei", {4'h0, bus.sm_wei}, 8'h0F);
        chk("midreset_duan", bus.sm_duan, 8'hFF);
        chk("midreset_fd", {7'd0, bus.frame_done}, 8'd0);
        rst = 1'b0;
        repeat (3) step();
        chk("resume_wei", {4'h0, bus.sm_wei}, 8'h0E);
        repeat (1500) begin
            if ($urandom_range(0, 9) == 0) begin
                bus.bcd = 16'($urandom) & masks[$urandom_range(0, 4)];
                bus.dp_en = 4'($urandom);
                bus.lz_blank = 1'($urandom);
            end
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        repeat (40) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
